// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 BCD display writer.
// Holds command bytes, ASCII codes, counter width and the top-state enum.
package lcd_pkg;

    localparam int WAIT_W = 20;

    localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_Q     = 8'h3F;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CFG,
        IDLE,
        ADDR,
        DIG0,
        DIG1,
        DIG2
    } top_state_t;

    // Non-BCD values show as '?' so a corrupt count is visible.
    function automatic logic [7:0] bcd_ascii(input logic [3:0] v);
        return (v > 4'd9) ? ASCII_Q : (ASCII_ZERO | {4'h0, v});
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit transfer engine: one nibble or a full byte plus post-wait.
// Ports: clk, reset (async low), start/nibble_only/rs/tx_byte/post_wait in,
// done (one-cycle, start may be re-asserted in that cycle), lcd_e/lcd_rs/lcd_data out.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int E_HIGH_CYC  = 12,
    parameter int NIB_GAP_CYC = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              nibble_only,
    input  logic              rs,
    input  logic [7:0]        tx_byte,
    input  logic [WAIT_W-1:0] post_wait,
    output logic              done,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic [3:0]        lcd_data
);

    typedef enum logic [2:0] {
        T_IDLE,
        T_SETUP,
        T_EHI,
        T_HOLD,
        T_GAP,
        T_WAIT
    } tx_state_t;

    tx_state_t         state, state_n;
    logic [WAIT_W-1:0] cnt, cnt_n;
    logic [WAIT_W-1:0] wait_r, wait_n;
    logic [3:0]        nib_r, nib_n;
    logic [3:0]        lo_r, lo_n;
    logic              two_r, two_n;
    logic              e_r, e_n;
    logic              rs_r, rs_n;
    logic              load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= T_IDLE;
            cnt    <= '0;
            wait_r <= '0;
            nib_r  <= 4'h0;
            lo_r   <= 4'h0;
            two_r  <= 1'b0;
            e_r    <= 1'b0;
            rs_r   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            wait_r <= wait_n;
            nib_r  <= nib_n;
            lo_r   <= lo_n;
            two_r  <= two_n;
            e_r    <= e_n;
            rs_r   <= rs_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wait_n  = wait_r;
        nib_n   = nib_r;
        lo_n    = lo_r;
        two_n   = two_r;
        e_n     = e_r;
        rs_n    = rs_r;
        done    = 1'b0;
        load    = 1'b0;
        unique case (state)
            T_IDLE: load = start;
            T_SETUP: begin
                e_n     = 1'b1;
                cnt_n   = WAIT_W'(E_HIGH_CYC - 1);
                state_n = T_EHI;
            end
            T_EHI: begin
                if (cnt == '0) begin
                    e_n     = 1'b0;
                    state_n = T_HOLD;
                end else begin
                    cnt_n = cnt - WAIT_W'(1);
                end
            end
            // Data/rs stay on the pins through this cycle after E falls.
            T_HOLD: begin
                if (two_r) begin
                    two_n   = 1'b0;
                    cnt_n   = WAIT_W'(NIB_GAP_CYC - 1);
                    state_n = T_GAP;
                end else begin
                    cnt_n   = wait_r - WAIT_W'(1);
                    state_n = T_WAIT;
                end
            end
            T_GAP: begin
                if (cnt == '0) begin
                    nib_n   = lo_r;
                    state_n = T_SETUP;
                end else begin
                    cnt_n = cnt - WAIT_W'(1);
                end
            end
            T_WAIT: begin
                if (cnt == '0) begin
                    done    = 1'b1;
                    state_n = T_IDLE;
                    load    = start;
                end else begin
                    cnt_n = cnt - WAIT_W'(1);
                end
            end
            default: state_n = T_IDLE;
        endcase
        // Loading drives rs/data straight onto the pins: that is the setup cycle.
        if (load) begin
            rs_n    = rs;
            nib_n   = nibble_only ? tx_byte[3:0] : tx_byte[7:4];
            lo_n    = tx_byte[3:0];
            two_n   = !nibble_only;
            wait_n  = post_wait;
            state_n = T_SETUP;
        end
    end

    assign lcd_e    = e_r;
    assign lcd_rs   = rs_r;
    assign lcd_data = nib_r;

endmodule

// File: rtl/lcd_bcd_writer.sv
// Writes a 3-digit BCD count to the HD44780 LCD after power-on init.
// Ports: clk, reset (async low), upd + hundreds/tens/ones in; ready, busy,
// lcd_rs/lcd_rw/lcd_e/lcd_4..7 out. Define LCD_LZB_EN for leading-zero blanking.
module lcd_bcd_writer
    import lcd_pkg::*;
#(
    parameter int         PWRUP_CYC    = 750000,
    parameter int         E_HIGH_CYC   = 12,
    parameter int         NIB_GAP_CYC  = 50,
    parameter int         CMD_WAIT_CYC = 2000,
    parameter int         CLR_WAIT_CYC = 82000,
    parameter int         INIT_W1_CYC  = 205000,
    parameter int         INIT_W2_CYC  = 5000,
    parameter logic [6:0] DISP_ADDR    = 7'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic       ready,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       lcd_4,
    output logic       lcd_5,
    output logic       lcd_6,
    output logic       lcd_7
);

    top_state_t        state, state_n;
    logic [1:0]        step, step_n;
    logic [WAIT_W-1:0] pwr_cnt;
    logic              armed;
    logic              pend;
    logic              ready_r;
    logic [1:0]        lat_h, cur_h;
    logic [3:0]        lat_t, cur_t;
    logic [3:0]        lat_o, cur_o;

    logic              upd_ok;
    logic              req;
    logic              start;
    logic              nib_only;
    logic              tx_rs;
    logic [7:0]        tx_byte;
    logic [WAIT_W-1:0] post_wait;
    logic              done;
    logic [3:0]        nib;
    logic [7:0]        dig_h, dig_t, dig_o;

    // armed is low in the first cycle after reset release, dropping that strobe.
    assign upd_ok = upd & armed;
    assign req    = upd_ok | pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= PWR_WAIT;
            step    <= 2'd0;
            pwr_cnt <= '0;
            armed   <= 1'b0;
            pend    <= 1'b0;
            ready_r <= 1'b0;
            lat_h   <= 2'd0;
            lat_t   <= 4'd0;
            lat_o   <= 4'd0;
            cur_h   <= 2'd0;
            cur_t   <= 4'd0;
            cur_o   <= 4'd0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            armed   <= 1'b1;
            pwr_cnt <= (state == PWR_WAIT) ? pwr_cnt + WAIT_W'(1) : '0;
            if (state_n == IDLE)
                ready_r <= 1'b1;
            if (upd_ok) begin
                lat_h <= hundreds;
                lat_t <= tens;
                lat_o <= ones;
            end
            // The write in flight uses its own copy, so later strobes only
            // affect the next write.
            if (state == IDLE && req) begin
                pend  <= 1'b0;
                cur_h <= upd_ok ? hundreds : lat_h;
                cur_t <= upd_ok ? tens : lat_t;
                cur_o <= upd_ok ? ones : lat_o;
            end else if (upd_ok) begin
                pend <= 1'b1;
            end
        end
    end

    always_comb begin
        dig_h = bcd_ascii({2'b00, cur_h});
        dig_t = bcd_ascii(cur_t);
        dig_o = bcd_ascii(cur_o);
`ifdef LCD_LZB_EN
        if (cur_h == 2'd0) begin
            dig_h = ASCII_SPACE;
            if (cur_t == 4'd0)
                dig_t = ASCII_SPACE;
        end
`endif
    end

    // Each transition into a sending step issues start with that step's byte.
    always_comb begin
        state_n   = state;
        step_n    = step;
        start     = 1'b0;
        nib_only  = 1'b0;
        tx_rs     = 1'b0;
        tx_byte   = 8'h00;
        post_wait = WAIT_W'(CMD_WAIT_CYC);
        unique case (state)
            PWR_WAIT: begin
                if (pwr_cnt == WAIT_W'(PWRUP_CYC - 1)) begin
                    state_n   = INIT;
                    step_n    = 2'd0;
                    start     = 1'b1;
                    nib_only  = 1'b1;
                    tx_byte   = 8'h03;
                    post_wait = WAIT_W'(INIT_W1_CYC);
                end
            end
            INIT: begin
                if (done) begin
                    start = 1'b1;
                    if (step == 2'd3) begin
                        state_n = CFG;
                        step_n  = 2'd0;
                        tx_byte = CMD_FUNC_4BIT;
                    end else begin
                        step_n   = step + 2'd1;
                        nib_only = 1'b1;
                        tx_byte  = (step == 2'd2) ? 8'h02 : 8'h03;
                        if (step == 2'd0)
                            post_wait = WAIT_W'(INIT_W2_CYC);
                    end
                end
            end
            CFG: begin
                if (done) begin
                    if (step == 2'd3) begin
                        state_n = IDLE;
                    end else begin
                        step_n = step + 2'd1;
                        start  = 1'b1;
                        unique case (step)
                            2'd0:    tx_byte = CMD_ENTRY;
                            2'd1:    tx_byte = CMD_DISP_ON;
                            default: begin
                                tx_byte   = CMD_CLEAR;
                                post_wait = WAIT_W'(CLR_WAIT_CYC);
                            end
                        endcase
                    end
                end
            end
            IDLE: begin
                if (req) begin
                    state_n = ADDR;
                    start   = 1'b1;
                    tx_byte = CMD_SET_DDRAM | {1'b0, DISP_ADDR};
                end
            end
            ADDR: begin
                if (done) begin
                    state_n = DIG0;
                    start   = 1'b1;
                    tx_rs   = 1'b1;
                    tx_byte = dig_h;
                end
            end
            DIG0: begin
                if (done) begin
                    state_n = DIG1;
                    start   = 1'b1;
                    tx_rs   = 1'b1;
                    tx_byte = dig_t;
                end
            end
            DIG1: begin
                if (done) begin
                    state_n = DIG2;
                    start   = 1'b1;
                    tx_rs   = 1'b1;
                    tx_byte = dig_o;
                end
            end
            DIG2: begin
                if (done)
                    state_n = IDLE;
            end
            default: state_n = PWR_WAIT;
        endcase
    end

    lcd_nibble_tx #(
        .E_HIGH_CYC  (E_HIGH_CYC),
        .NIB_GAP_CYC (NIB_GAP_CYC)
    ) u_tx (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .nibble_only (nib_only),
        .rs          (tx_rs),
        .tx_byte     (tx_byte),
        .post_wait   (post_wait),
        .done        (done),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_data    (nib)
    );

    // A pending request keeps busy high through its one IDLE cycle.
    assign busy   = (state != IDLE) || pend;
    assign ready  = ready_r;
    assign lcd_rw = 1'b0;
    assign lcd_4  = nib[0];
    assign lcd_5  = nib[1];
    assign lcd_6  = nib[2];
    assign lcd_7  = nib[3];

endmodule

// File: tb/tb_lcd_bcd_writer.sv
// Scoreboard bench for lcd_bcd_writer with shortened timing parameters.
// Expected {rs,nibble} values are queued at stimulus; a monitor checks each E fall.
module tb_lcd_bcd_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       upd = 1'b0;
    logic [1:0] hundreds = 2'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       ready, busy, lcd_rs, lcd_rw, lcd_e;
    logic       lcd_4, lcd_5, lcd_6, lcd_7;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] expq[$];
    logic [4:0] ex_nib;
    logic       e_q = 1'b0;
    logic       rw_bad = 1'b0;

    lcd_bcd_writer #(
        .PWRUP_CYC    (100),
        .E_HIGH_CYC   (3),
        .NIB_GAP_CYC  (2),
        .CMD_WAIT_CYC (8),
        .CLR_WAIT_CYC (30),
        .INIT_W1_CYC  (40),
        .INIT_W2_CYC  (10),
        .DISP_ADDR    (7'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .upd      (upd),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .ready    (ready),
        .busy     (busy),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_4    (lcd_4),
        .lcd_5    (lcd_5),
        .lcd_6    (lcd_6),
        .lcd_7    (lcd_7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            e_q = 1'b0;
        end else begin
            if (lcd_rw !== 1'b0)
                rw_bad = 1'b1;
            if (e_q && !lcd_e) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_nibble actual %0h expected none",
                             {lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4});
                end else begin
                    ex_nib = expq.pop_front();
                    chk("nibble", {27'b0, lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4},
                        {27'b0, ex_nib});
                end
            end
            e_q = lcd_e;
        end
    end

    task automatic push_byte(input logic rs, input logic [7:0] b);
        expq.push_back({rs, b[7:4]});
        expq.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        expq.push_back(5'h03);
        expq.push_back(5'h03);
        expq.push_back(5'h03);
        expq.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_upd(input logic [7:0] h, input logic [7:0] t,
                            input logic [7:0] o);
        push_byte(1'b0, 8'h80);
        push_byte(1'b1, h);
        push_byte(1'b1, t);
        push_byte(1'b1, o);
    endtask

    task automatic send_upd(input logic [1:0] h, input logic [3:0] t,
                            input logic [3:0] o);
        upd = 1'b1;
        hundreds = h;
        tens = t;
        ones = o;
        @(posedge clk); #1;
        upd = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((busy || expq.size() != 0) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(ready), 32'd1);
    endtask

    initial begin
        int seen;
        int gap;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_data", 32'({lcd_7, lcd_6, lcd_5, lcd_4}), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Release with a coincident strobe, which must be dropped.
        reset = 1'b1;
        push_init();
        send_upd(2'd3, 4'd3, 4'd3);
        seen = 0;
        repeat (99) begin
            @(posedge clk); #1;
            if (lcd_e) seen++;
        end
        chk("pwrup_quiet", 32'(seen), 32'd0);
        wait_ready("init_ready");
        chk("init_drained", 32'(expq.size()), 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy) seen++;
        end
        chk("release_upd_ignored", 32'(seen), 32'd0);

        // Update from IDLE with exact handshake timing.
        chk("idle_busy", 32'(busy), 32'd0);
        push_upd(8'h31, 8'h32, 8'h37);
        send_upd(2'd1, 4'd2, 4'd7);
        chk("busy_next_cycle", 32'(busy), 32'd1);
        chk("e_low_setup", 32'(lcd_e), 32'd0);
        @(posedge clk); #1;
        chk("e_rise_2cyc", 32'(lcd_e), 32'd1);
        wait_done("upd127_done");
        chk("busy_fall", 32'(busy), 32'd0);

        // Back-to-back: 009 is overwritten by 013 while busy.
`ifdef LCD_LZB_EN
        push_upd(8'h20, 8'h20, 8'h35);
        push_upd(8'h20, 8'h31, 8'h33);
`else
        push_upd(8'h30, 8'h30, 8'h35);
        push_upd(8'h30, 8'h31, 8'h33);
`endif
        send_upd(2'd0, 4'd0, 4'd5);
        repeat (10) @(posedge clk);
        #1;
        send_upd(2'd0, 4'd0, 4'd9);
        repeat (5) @(posedge clk);
        #1;
        send_upd(2'd0, 4'd1, 4'd3);
        gap = 0;
        n = 0;
        while (expq.size() != 0 && n < 5000) begin
            @(posedge clk); #1;
            if (!busy) gap++;
            n++;
        end
        chk("b2b_no_idle", 32'(gap), 32'd0);
        wait_done("b2b_done");

        // Digit encoding.
`ifdef LCD_LZB_EN
        push_upd(8'h20, 8'h3F, 8'h34);
`else
        push_upd(8'h30, 8'h3F, 8'h34);
`endif
        send_upd(2'd0, 4'hB, 4'd4);
        wait_done("enc_0B4");
`ifdef LCD_LZB_EN
        push_upd(8'h20, 8'h20, 8'h37);
`else
        push_upd(8'h30, 8'h30, 8'h37);
`endif
        send_upd(2'd0, 4'd0, 4'd7);
        wait_done("enc_007");
`ifdef LCD_LZB_EN
        push_upd(8'h20, 8'h33, 8'h30);
`else
        push_upd(8'h30, 8'h33, 8'h30);
`endif
        send_upd(2'd0, 4'd3, 4'd0);
        wait_done("enc_030");
        push_upd(8'h33, 8'h39, 8'h39);
        send_upd(2'd3, 4'd9, 4'd9);
        wait_done("enc_399");

        // Reset while E is high aborts the write.
        send_upd(2'd1, 4'd1, 4'd1);
        n = 0;
        while (!lcd_e && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("e_high_seen", 32'(lcd_e), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_e", 32'(lcd_e), 32'd0);
        chk("mid_rst_pins", 32'({lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4}), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        expq.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        push_init();
        repeat (50) @(posedge clk);
        #1;
        push_upd(8'h32, 8'h34, 8'h36);
        send_upd(2'd2, 4'd4, 4'd6);
        wait_ready("reinit_ready");
        chk("pend_busy_at_ready", 32'(busy), 32'd1);
        wait_done("init_upd_done");

        chk("rw_low", 32'(rw_bad), 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
